// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock through a single full-adder cell,
// LSB first, with a carry flip-flop between cycles and a one-cycle done pulse.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             fa_s, fa_c;

    full_adder u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift-then-insert keeps the same form legal for WIDTH = 1.
                sh_d          = sh_q >> 1;
                sh_d[WIDTH-1] = fa_s;
                opa_d         = opa_q >> 1;
                opb_d         = opb_q >> 1;
                carry_d       = fa_c;
                cnt_d         = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sh_d;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked through a result scoreboard,
// plus a WIDTH=1 instance checked directly.

module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, cin;
    logic [7:0] a, b;
    logic       busy, done, co, ov;
    logic [7:0] sum;

    logic       r1, s1, ci1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, co1, ov1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carry_in(cin),
        .busy(busy), .done(done), .sum(sum), .carry_out(co), .overflow(ov)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(r1), .start(s1), .a(a1), .b(b1), .carry_in(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1), .overflow(ov1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("carry_out", 32'(co), 32'(e.co));
                check("overflow", 32'(ov), 32'(e.ov));
            end
        end
    end

    function automatic vec_t model(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        vec_t       r;
        logic [8:0] full;
        logic [7:0] low;
        full  = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
        low   = {1'b0, va[6:0]} + {1'b0, vb[6:0]} + {7'd0, vc};
        r.a   = va;
        r.b   = vb;
        r.cin = vc;
        r.s   = full[7:0];
        r.co  = full[8];
        r.ov  = low[7] ^ full[8];
        return r;
    endfunction

    // Counts edges from the accepting edge (inclusive) until done is seen.
    task automatic wait_done(input bit drop_start, input bit interfere,
                             output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (drop_start && edges == 1) begin
                start = 1'b0;
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
            end
            if (interfere && edges == 4) begin
                start = 1'b1;
                a = 8'hAA;
            end
            if (interfere && edges == 5) start = 1'b0;
            if (done) break;
            if (busy) busy_cycles++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d edges expected done", edges);
        end
    endtask

    task automatic run_op(input vec_t v, input bit interfere);
        int edges, bc;
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb.push_back(v);
        wait_done(1'b1, interfere, edges, bc);
        check("latency", 32'(edges), 32'd9);
        check("busy_cycles", 32'(bc), 32'd8);
        check("busy_at_done", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("sum_hold", 32'(sum), 32'(v.s));
    endtask

    vec_t tbl[7];

    initial begin
        int edges, bc;
        tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
        r1 = 1'b1; s1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(co), 32'd0);
        check("rst_ovf", 32'(ov), 32'd0);
        reset = 1'b0;
        r1 = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) run_op(tbl[i], 1'b0);
        for (int i = 0; i < 4; i++) run_op(model(8'($urandom), 8'($urandom), 1'($urandom)), 1'b0);

        // start while busy: ignored, no second done
        run_op(model(8'h10, 8'h20, 1'b0), 1'b1);

        // back-to-back with start held high
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        wait_done(1'b0, 1'b0, edges, bc);
        check("b2b_latency1", 32'(edges), 32'd9);
        a = 8'h0F; b = 8'hF0;
        sb.push_back(model(8'h0F, 8'hF0, 1'b0));
        wait_done(1'b0, 1'b0, edges, bc);
        check("b2b_spacing", 32'(edges), 32'd9);
        check("b2b_busy", 32'(bc), 32'd8);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset at RUN bit 4
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(co), 32'd0);
        check("abort_ovf", 32'(ov), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_still_idle", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // WIDTH = 1 instance
        for (int i = 0; i < 3; i++) begin
            logic [0:0] va, vb;
            logic       vc, es, eco, eov;
            va = (i == 2) ? 1'b0 : 1'b1;
            vb = (i == 0) ? 1'b1 : 1'b0;
            vc = (i != 1);
            es  = va[0] ^ vb[0] ^ vc;
            eco = (va[0] & vb[0]) | (va[0] & vc) | (vb[0] & vc);
            eov = vc ^ eco;
            a1 = va; b1 = vb; ci1 = vc; s1 = 1'b1;
            edges = 0;
            while (edges < 10) begin
                @(posedge clk); #1;
                edges++;
                if (edges == 1) s1 = 1'b0;
                if (done1) break;
            end
            check("w1_latency", 32'(edges), 32'd2);
            check("w1_sum", 32'(sum1), 32'(es));
            check("w1_cout", 32'(co1), 32'(eco));
            check("w1_ovf", 32'(ov1), 32'(eov));
            @(posedge clk); #1;
            check("w1_done_pulse", 32'(done1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
